// File: rtl/fir_mac_seq_if.sv
// Sample/coefficient/result bundle for fir_mac_seq.
// The master drives samples and coefficients; the slave (the filter) drives results.
interface fir_mac_seq_if #(
    parameter int DATA_W = 6,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8
);
    logic signed [DATA_W-1:0] x_n;
    logic                     in_valid;
    logic                     in_ready;
    logic                     coef_load;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [OUT_W-1:0]  y_n;
    logic                     out_valid;

    modport master (
        output x_n, in_valid, coef_load, coef_data,
        input  in_ready, y_n, out_valid
    );

    modport slave (
        input  x_n, in_valid, coef_load, coef_data,
        output in_ready, y_n, out_valid
    );
endinterface

// File: rtl/fir_mac_seq.sv
// Sequential FIR filter: one shared multiplier steps through the taps (IDLE -> MAC x NUM_TAPS -> OUT).
// Optional macro FIR_MAC_SEQ_SAT_EN saturates the scaled result; otherwise it wraps to OUT_W bits.
module fir_mac_seq #(
    parameter int DATA_W   = 6,
    parameter int COEF_W   = 8,
    parameter int NUM_TAPS = 4,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    fir_mac_seq_if.slave  bus
);
    localparam int IDX_W  = $clog2(NUM_TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + IDX_W;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state_reg;
    logic [IDX_W-1:0]         tap_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic signed [OUT_W-1:0]  y_reg;
    logic                     out_valid_reg;

    logic signed [DATA_W-1:0] x_reg [NUM_TAPS];
    logic signed [COEF_W-1:0] c_reg [NUM_TAPS];

    logic accept;
    logic coef_shift;

    // A sample wins over a coefficient strobe when both arrive in IDLE.
    assign accept     = (state_reg == IDLE) && bus.in_valid;
    assign coef_shift = (state_reg == IDLE) && bus.coef_load && !bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg[0] <= '0;
            c_reg[0] <= '0;
        end else begin
            if (accept)
                x_reg[0] <= bus.x_n;
            if (coef_shift)
                c_reg[0] <= bus.coef_data;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < NUM_TAPS; gi++) begin : g_delay
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_reg[gi] <= '0;
                    c_reg[gi] <= '0;
                end else begin
                    if (accept)
                        x_reg[gi] <= x_reg[gi-1];
                    if (coef_shift)
                        c_reg[gi] <= c_reg[gi-1];
                end
            end
        end
    endgenerate

    logic signed [DATA_W-1:0] x_sel;
    logic signed [COEF_W-1:0] c_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [OUT_W-1:0]  y_calc;

    assign x_sel  = x_reg[tap_reg];
    assign c_sel  = c_reg[tap_reg];
    assign prod   = PROD_W'(x_sel) * PROD_W'(c_sel);
    assign scaled = acc_reg >>> SHIFT;

    generate
        if (OUT_W > ACC_W) begin : g_widen
            assign y_calc = OUT_W'(scaled);
        end else begin : g_narrow
`ifdef FIR_MAC_SEQ_SAT_EN
            localparam logic signed [ACC_W-1:0] MAX_V =
                {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] MIN_V =
                {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            always_comb begin
                y_calc = scaled[OUT_W-1:0];
                if (scaled > MAX_V)
                    y_calc = MAX_V[OUT_W-1:0];
                else if (scaled < MIN_V)
                    y_calc = MIN_V[OUT_W-1:0];
            end
`else
            logic unused_hi;
            assign unused_hi = ^scaled;
            assign y_calc    = scaled[OUT_W-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            tap_reg       <= '0;
            acc_reg       <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        acc_reg   <= '0;
                        tap_reg   <= '0;
                        state_reg <= MAC;
                    end
                end
                MAC: begin
                    // Accumulator carries clog2(NUM_TAPS) guard bits, so the sum cannot overflow.
                    acc_reg <= acc_reg + ACC_W'(prod);
                    if (tap_reg == IDX_W'(NUM_TAPS - 1)) begin
                        state_reg <= OUT;
                    end else begin
                        tap_reg <= tap_reg + IDX_W'(1);
                    end
                end
                OUT: begin
                    y_reg         <= y_calc;
                    out_valid_reg <= 1'b1;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.y_n       = y_reg;
    assign bus.out_valid = out_valid_reg;
endmodule
